// File: rtl/axi_sts_event_counter.sv
// Per-channel event counters with sticky overflow flags and a coherent, registered
// snapshot image for the AXI status register.
module axi_sts_event_counter #(
    parameter int NUM_CH    = 8,
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 1,
    parameter int EDGE      = 1,
    localparam int STS_DATA_WIDTH = 32 * (NUM_CH + 1)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_CH-1:0]         evt_in,
    input  logic                      cfg_enable,
    input  logic                      cfg_snap,
    input  logic                      cfg_clear,
    output logic [STS_DATA_WIDTH-1:0] sts_data,
    output logic                      snap_done
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0]    evt_prev;
    logic                 snap_prev;
    logic                 clr_prev;
    logic [NUM_CH-1:0]    hit;
    logic                 snap_req;
    logic                 clr_req;
    logic [CNT_WIDTH-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0]    ovf;
    logic [7:0]           snap_seq;
    logic [STS_DATA_WIDTH-1:0] snap_image;

    assign hit      = (EDGE != 0) ? (evt_in & ~evt_prev) : evt_in;
    assign snap_req = cfg_snap & ~snap_prev;
    assign clr_req  = cfg_clear & ~clr_prev;

    // The sequence number lives in the registered image itself; no separate copy.
    assign snap_seq = sts_data[31:24];

    // Previous-value registers update every cycle, independent of cfg_enable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            evt_prev  <= '0;
            snap_prev <= 1'b0;
            clr_prev  <= 1'b0;
        end else begin
            evt_prev  <= evt_in;
            snap_prev <= cfg_snap;
            clr_prev  <= cfg_clear;
        end
    end

    // NOTE: the counter array is reset element by element because software must
    // never see stale counts after reset; do not drop the loop to save reset fan-out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            ovf <= '0;
        end else if (clr_req) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            ovf <= '0;
        end else if (cfg_enable) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        cnt[i] <= (SATURATE != 0) ? CNT_MAX : '0;
                        ovf[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Image built from the pre-update live state, so a coincident clear cannot leak in.
    always_comb begin
        snap_image               = '0;
        snap_image[NUM_CH-1:0]   = ovf;
        snap_image[31:24]        = snap_seq + 8'd1;
        for (int k = 0; k < NUM_CH; k++) begin
            snap_image[32*(k+1) +: CNT_WIDTH] = cnt[k];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_data  <= '0;
            snap_done <= 1'b0;
        end else begin
            snap_done <= snap_req;
            if (snap_req) sts_data <= snap_image;
        end
    end

endmodule

// File: tb/tb_axi_sts_event_counter.sv
// Randomized and directed bench for axi_sts_event_counter: three parameterisations
// checked every cycle against an integer-arithmetic reference model.
module tb_axi_sts_event_counter;

    localparam int NM = 3;
    localparam int CFG_NCH [NM] = '{8, 3, 3};
    localparam longint CFG_MAX [NM] = '{64'hFFFF_FFFF, 15, 15};
    localparam int CFG_SAT [NM] = '{1, 0, 1};
    localparam int CFG_EDGE [NM] = '{1, 0, 1};

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [7:0]   evt = '0;
    logic         en = 1'b0;
    logic         snap = 1'b0;
    logic         clr = 1'b0;
    logic [287:0] sts_a;
    logic [127:0] sts_b;
    logic [127:0] sts_c;
    logic         done_a, done_b, done_c;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_sts_event_counter dut_a (
        .aclk(aclk), .aresetn(aresetn), .evt_in(evt), .cfg_enable(en),
        .cfg_snap(snap), .cfg_clear(clr), .sts_data(sts_a), .snap_done(done_a)
    );

    axi_sts_event_counter #(.NUM_CH(3), .CNT_WIDTH(4), .SATURATE(0), .EDGE(0)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .evt_in(evt[2:0]), .cfg_enable(en),
        .cfg_snap(snap), .cfg_clear(clr), .sts_data(sts_b), .snap_done(done_b)
    );

    axi_sts_event_counter #(.NUM_CH(3), .CNT_WIDTH(4), .SATURATE(1), .EDGE(1)) dut_c (
        .aclk(aclk), .aresetn(aresetn), .evt_in(evt[2:0]), .cfg_enable(en),
        .cfg_snap(snap), .cfg_clear(clr), .sts_data(sts_c), .snap_done(done_c)
    );

    // Reference model state: counts as plain integers.
    longint   m_cnt    [NM][8];
    longint   m_shadow [NM][8];
    bit [7:0] m_ovf    [NM];
    bit [7:0] m_ovfs   [NM];
    bit [7:0] m_eprev  [NM];
    int       m_seq    [NM];
    bit       m_done   [NM];
    bit       m_snap_prev;
    bit       m_clr_prev;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < NM; m++) begin
            for (int i = 0; i < 8; i++) begin
                m_cnt[m][i] = 0;
                m_shadow[m][i] = 0;
            end
            m_ovf[m] = '0; m_ovfs[m] = '0; m_eprev[m] = '0;
            m_seq[m] = 0; m_done[m] = 1'b0;
        end
        m_snap_prev = 1'b0;
        m_clr_prev = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] e, input logic en_v,
                                       input logic snap_v, input logic clr_v);
        bit sreq = snap_v && !m_snap_prev;
        bit creq = clr_v && !m_clr_prev;
        for (int m = 0; m < NM; m++) begin
            bit [7:0] hits = '0;
            for (int i = 0; i < CFG_NCH[m]; i++)
                hits[i] = (CFG_EDGE[m] != 0) ? (e[i] && !m_eprev[m][i]) : e[i];
            m_done[m] = sreq;
            if (sreq) begin
                for (int i = 0; i < 8; i++) m_shadow[m][i] = m_cnt[m][i];
                m_ovfs[m] = m_ovf[m];
                m_seq[m] = (m_seq[m] + 1) % 256;
            end
            if (creq) begin
                for (int i = 0; i < 8; i++) m_cnt[m][i] = 0;
                m_ovf[m] = '0;
            end else if (en_v) begin
                for (int i = 0; i < CFG_NCH[m]; i++) begin
                    if (hits[i]) begin
                        if (m_cnt[m][i] == CFG_MAX[m]) begin
                            m_ovf[m][i] = 1'b1;
                            m_cnt[m][i] = (CFG_SAT[m] != 0) ? CFG_MAX[m] : 0;
                        end else begin
                            m_cnt[m][i] = m_cnt[m][i] + 1;
                        end
                    end
                end
            end
            m_eprev[m] = e;
        end
        m_snap_prev = snap_v;
        m_clr_prev = clr_v;
    endfunction

    function automatic logic [287:0] model_image(input int m);
        logic [287:0] v = '0;
        for (int i = 0; i < CFG_NCH[m]; i++) begin
            v[i] = m_ovfs[m][i];
            v[32*(i+1) +: 32] = m_shadow[m][i][31:0];
        end
        v[31:24] = m_seq[m][7:0];
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [287:0] v, input int k);
        return v[32*k +: 32];
    endfunction

    task automatic check_all();
        check("done_a", done_a, m_done[0]);
        check("done_b", done_b, m_done[1]);
        check("done_c", done_c, m_done[2]);
        check("sts_a", sts_a, model_image(0));
        check("sts_b", {160'b0, sts_b}, model_image(1));
        check("sts_c", {160'b0, sts_c}, model_image(2));
    endtask

    task automatic cycle(input logic [7:0] e, input logic en_v, input logic snap_v,
                         input logic clr_v);
        @(negedge aclk);
        evt = e; en = en_v; snap = snap_v; clr = clr_v;
        model_step(e, en_v, snap_v, clr_v);
        @(posedge aclk);
        #1;
        check_all();
    endtask

    task automatic pulses(input logic [7:0] e, input int n, input logic en_v);
        for (int p = 0; p < n; p++) begin
            cycle(e, en_v, 1'b0, 1'b0);
            cycle(8'h00, en_v, 1'b0, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sts_a"}, sts_a, '0);
        check({tag, "_sts_b"}, {160'b0, sts_b}, '0);
        check({tag, "_sts_c"}, {160'b0, sts_c}, '0);
        check({tag, "_done"}, {done_a, done_b, done_c}, '0);
    endtask

    initial begin
        int ndone;
        int seq_start;
        model_reset();
        #2;
        check_zero("reset");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        // Five pulses on ch0 then a snapshot.
        pulses(8'h01, 5, 1'b1);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t1_word1", word_of(sts_a, 1), 32'd5);
        check("t1_seq", sts_a[31:24], 8'd1);
        check("t1_done", done_a, 1'b1);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t1_done_once", done_a, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);

        // Level held on ch1 for 10 cycles.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(8'h02, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t2_edge_word2", word_of(sts_a, 2), 32'd1);
        check("t2_level_word2", word_of({160'b0, sts_b}, 2), 32'd10);

        // Overflow on 4-bit counters: saturate vs wrap.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        pulses(8'h04, 20, 1'b1);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t3_sat_word3", word_of({160'b0, sts_c}, 3), 32'd15);
        check("t3_sat_ovf2", sts_c[2], 1'b1);
        check("t3_wrap_word3", word_of({160'b0, sts_b}, 3), 32'd4);
        check("t3_wrap_ovf2", sts_b[2], 1'b1);

        // Snapshot and clear on the same edge.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        pulses(8'h01, 7, 1'b1);
        cycle(8'h00, 1'b1, 1'b1, 1'b1);
        check("t4_word1", word_of(sts_a, 1), 32'd7);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        pulses(8'h01, 3, 1'b1);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t4_word1_after", word_of(sts_a, 1), 32'd3);
        check("t4_seq", sts_a[31:24], 8'd5);
        check("t4_ovf", sts_c[2:0], 3'b000);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);

        // cfg_snap held high for 100 cycles.
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(8'h00, 1'b1, 1'b1, 1'b0);
            if (done_a) ndone++;
        end
        check("t5_one_done", ndone, 1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        seq_start = m_seq[0];
        for (int i = 0; i < 256; i++) begin
            cycle(8'h00, 1'b1, 1'b1, 1'b0);
            cycle(8'h00, 1'b1, 1'b0, 1'b0);
        end
        check("t5_seq_wrap", sts_a[31:24], seq_start[7:0]);

        // Disabled counting.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        pulses(8'h01, 3, 1'b1);
        pulses(8'h01, 6, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        check("t6_hold_word1", word_of(sts_a, 1), 32'd3);

        // Asynchronous reset right after a snapshot, away from any edge.
        pulses(8'h07, 4, 1'b1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        evt = '0; snap = 1'b1; clr = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        // cfg_snap already high at release: snapshot on the first edge.
        @(posedge aclk);
        model_step(8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        check_all();
        check("rel_snap_done", done_a, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(8'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
